dcache_refill_ctrl: RTL and testbench

- Miss-handling controller that sits directly downstream of the 4-way set-associative data cache, between the cache and word-wide main memory.
- On a cache miss it writes back a dirty victim block (4 beats) if needed, then fetches the missing block (4 beats).
- It presents the fetched block to the cache with a one-cycle update pulse and stalls the CPU for the whole sequence.

---
 rtl/dcache_refill_ctrl_pkg.sv | 36 +++
 rtl/dcache_refill_ctrl_mem_burst_seq.sv | 39 +++
 rtl/dcache_refill_ctrl.sv | 131 +++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared cache geometry, address field positions and refill FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    localparam int NUM_SETS    = 4;
    localparam int WAYS        = 4;
    localparam int BLOCK_WORDS = 4;
    localparam int TAG_W       = 26;
    localparam int ADDR_W      = 32;

    // Byte-address field positions: word-in-block, set index, tag.
    localparam int WORD_LSB = 2;
    localparam int WORD_MSB = 3;
    localparam int SET_LSB  = 4;
    localparam int SET_MSB  = 5;
    localparam int TAG_LSB  = 6;
    localparam int TAG_MSB  = 31;

    // Addresses at or above this are memory-mapped IO and bypass the cache.
    localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL,
        ST_UPD,
        ST_SETTLE
    } refill_state_t;

    // Block-aligned base of a byte address (clears word and byte offsets).
    function automatic logic [31:0] block_base(input logic [31:0] a);
        return {a[TAG_MSB:SET_LSB], 4'b0000};
    endfunction

endpackage

// File: rtl/dcache_refill_ctrl_mem_burst_seq.sv
// Beat sequencer for one 4-beat memory burst: beat counter, base+4*beat address, last-beat flag.
// Latency: address is combinational from the registered beat; beat advances on the cycle after adv.
// Backpressure: beat only advances on adv (memory ack), so address holds while memory stalls.
//
// Ports: CLK/RST clock and async active-high reset; clr forces beat to 0; adv steps the beat;
//        base is the block-aligned burst base; beat/addr/last describe the current beat.
module mem_burst_seq
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    input  logic              adv,
    input  logic [ADDR_W-1:0] base,
    output logic [1:0]        beat,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [1:0] LAST_BEAT = 2'(BLOCK_WORDS - 1);

    // The 2-bit counter wraps naturally from 3 to 0, so the next burst needs no clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            beat <= 2'd0;
        end else if (clr) begin
            beat <= 2'd0;
        end else if (adv) begin
            beat <= beat + 2'd1;
        end
    end

    assign addr = base + {{(ADDR_W-4){1'b0}}, beat, 2'b00};
    assign last = (beat == LAST_BEAT);

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: writes back a dirty victim (4 beats), fetches the missing block (4 beats),
// then pulses update for one cycle and waits one settle cycle; stall covers the whole sequence.
// Latency: clean miss 6 cycles, dirty miss 10 cycles after the miss cycle with zero-wait memory;
// backpressure: each beat is held (req/addr/wdata stable) until mem_ack.
//
// Ports: CLK/RST; cpu_read/cpu_write/cpu_addr CPU request; cache_hit/cache_miss lookup result;
//        victim_dirty/victim_addr/victim_w0..3 LRU victim; fill_w0..3/update block install to cache;
//        stall CPU freeze; mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack word-wide memory port.
module dcache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int                BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int                ADDR_W      = cache_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = cache_pkg::MMIO_BASE
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cache_hit,
    input  logic              cache_miss,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [31:0]       victim_w0,
    input  logic [31:0]       victim_w1,
    input  logic [31:0]       victim_w2,
    input  logic [31:0]       victim_w3,
    output logic [31:0]       fill_w0,
    output logic [31:0]       fill_w1,
    output logic [31:0]       fill_w2,
    output logic [31:0]       fill_w3,
    output logic              update,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    refill_state_t     state;
    logic [ADDR_W-1:0] miss_base;
    logic [ADDR_W-1:0] lat_victim_addr;
    logic [31:0]       lat_victim_w [4];
    logic [31:0]       fill_q [4];

    logic              start;
    logic              in_burst;
    logic [1:0]        beat;
    logic [ADDR_W-1:0] seq_addr;
    logic              last;

    // A simultaneous hit and miss is treated as a hit; MMIO misses are never refilled.
    assign start = (cpu_read | cpu_write) & cache_miss & ~cache_hit & (cpu_addr < MMIO_BASE);

    assign in_burst = (state == ST_WB) || (state == ST_FILL);

    mem_burst_seq #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_seq (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (state == ST_IDLE),
        .adv  (in_burst & mem_ack),
        .base ((state == ST_WB) ? lat_victim_addr : miss_base),
        .beat (beat),
        .addr (seq_addr),
        .last (last)
    );

    // Only latched copies are used after the start cycle, so CPU/victim inputs may change freely.
    // The victim's dirty bit is captured by the choice of WB versus FILL as the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= ST_IDLE;
            miss_base       <= '0;
            lat_victim_addr <= '0;
            for (int i = 0; i < 4; i++) begin
                lat_victim_w[i] <= '0;
                fill_q[i]       <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        miss_base       <= block_base(cpu_addr);
                        lat_victim_addr <= victim_addr;
                        lat_victim_w[0] <= victim_w0;
                        lat_victim_w[1] <= victim_w1;
                        lat_victim_w[2] <= victim_w2;
                        lat_victim_w[3] <= victim_w3;
                        state           <= victim_dirty ? ST_WB : ST_FILL;
                    end
                end
                ST_WB: begin
                    if (mem_ack && last) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        fill_q[beat] <= mem_rdata;
                        if (last) begin
                            state <= ST_UPD;
                        end
                    end
                end
                ST_UPD:    state <= ST_SETTLE;
                ST_SETTLE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = in_burst;
    assign mem_we    = (state == ST_WB);
    assign mem_addr  = in_burst ? seq_addr : '0;
    assign mem_wdata = (state == ST_WB) ? lat_victim_w[beat] : 32'd0;
    assign update    = (state == ST_UPD);
    // Combinational so the pipeline freezes in the very cycle the miss is seen.
    assign stall     = (state != ST_IDLE) | start;

    assign fill_w0 = fill_q[0];
    assign fill_w1 = fill_q[1];
    assign fill_w2 = fill_q[2];
    assign fill_w3 = fill_q[3];

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
module tb_dcache_refill_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_read, cpu_write, cache_hit, cache_miss, victim_dirty;
    logic [31:0] cpu_addr, victim_addr;
    logic [31:0] victim_w0, victim_w1, victim_w2, victim_w3;
    logic [31:0] fill_w0, fill_w1, fill_w2, fill_w3;
    logic        update, stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 CLK = ~CLK;

    dcache_refill_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cache_hit    (cache_hit),
        .cache_miss   (cache_miss),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .victim_w0    (victim_w0),
        .victim_w1    (victim_w1),
        .victim_w2    (victim_w2),
        .victim_w3    (victim_w3),
        .fill_w0      (fill_w0),
        .fill_w1      (fill_w1),
        .fill_w2      (fill_w2),
        .fill_w3      (fill_w3),
        .update       (update),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input int vi, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %h want %h", vi, what, act, exp);
        end
    endtask

    // One miss scenario: CPU request, victim, memory wait states, optional mid-sequence reset,
    // optional back-to-back second miss, and hand-computed stall/update/beat counts.
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic        hit;
        logic        miss;
        logic        dirty;
        logic [31:0] vaddr;
        logic [31:0] vw0;
        int          waits;
        logic [31:0] seed;
        int          rst_at;
        logic [31:0] chain_addr;
        logic [31:0] seed2;
        int          exp_stall;
        int          exp_upd;
        int          exp_beats;
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input int vi, input vec_t v);
        int          stall_cnt = 0, upd_cnt = 0, nbeats = 0, req_cycles = 0, wc = 0;
        bit          done = 1'b0, rst_active = 1'b0;
        logic [31:0] rdseed;
        logic [31:0] la [16];
        logic [31:0] ld [16];
        logic        lwe [16];
        logic [31:0] cap [4];
        int          ne = 0;
        logic [31:0] ea [16];
        logic [31:0] ed [16];
        logic        ewe [16];
        logic [31:0] last_seed;
        logic [31:0] blk;

        rdseed = v.seed;
        for (int i = 0; i < 4; i++) cap[i] = 32'hx;

        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge CLK);
            if (rst_active) begin
                RST = 1'b0;
                rst_active = 1'b0;
            end
            if (c == 0) begin
                cpu_read = v.rd; cpu_write = v.wr; cpu_addr = v.addr;
                cache_hit = v.hit; cache_miss = v.miss; victim_dirty = v.dirty;
                victim_addr = v.vaddr;
                victim_w0 = v.vw0; victim_w1 = v.vw0 + 32'd1;
                victim_w2 = v.vw0 + 32'd2; victim_w3 = v.vw0 + 32'd3;
            end else if (c == 1 && v.chain_addr != 32'd0) begin
                cpu_addr = v.chain_addr;
            end else if (c == 1) begin
                cpu_read = 1'b0; cpu_write = 1'b0; cache_miss = 1'b0;
                cpu_addr = 32'h0000_7777; victim_dirty = ~v.dirty; victim_addr = 32'h0000_BAD0;
                victim_w0 = 32'hDEAD_0000; victim_w1 = 32'hDEAD_0001;
                victim_w2 = 32'hDEAD_0002; victim_w3 = 32'hDEAD_0003;
            end
            if (v.chain_addr != 32'd0 && nbeats >= 5) begin
                cpu_read = 1'b0; cpu_write = 1'b0; cache_miss = 1'b0;
            end
            #1;
            if (c > 0 && !stall) begin
                done = 1'b1;
            end else begin
                if (stall) stall_cnt++;
                if (update) begin
                    upd_cnt++;
                    cap[0] = fill_w0; cap[1] = fill_w1; cap[2] = fill_w2; cap[3] = fill_w3;
                    rdseed = v.seed2;
                end
                mem_ack = 1'b0;
                if (c == v.rst_at) begin
                    RST = 1'b1;
                    rst_active = 1'b1;
                    #1;
                    chk(vi, "rst_stall", {31'd0, stall}, 32'd0);
                    chk(vi, "rst_mem_req", {31'd0, mem_req}, 32'd0);
                    chk(vi, "rst_mem_addr", mem_addr, 32'd0);
                    chk(vi, "rst_fill_w0", fill_w0, 32'd0);
                    chk(vi, "rst_fill_w1", fill_w1, 32'd0);
                end else if (mem_req) begin
                    req_cycles++;
                    if (wc == v.waits) begin
                        mem_ack = 1'b1;
                        mem_rdata = rdseed + {30'd0, mem_addr[3:2]};
                        if (nbeats < 16) begin
                            la[nbeats] = mem_addr; ld[nbeats] = mem_wdata; lwe[nbeats] = mem_we;
                        end
                        nbeats++;
                        wc = 0;
                    end else begin
                        wc++;
                    end
                end
            end
        end
        mem_ack = 1'b0;

        chk(vi, "finished", {31'd0, done}, 32'd1);
        chk(vi, "stall_cycles", stall_cnt, v.exp_stall);
        chk(vi, "update_pulses", upd_cnt, v.exp_upd);
        chk(vi, "beats", nbeats, v.exp_beats);
        if (v.rst_at < 0) chk(vi, "req_cycles", req_cycles, v.exp_beats * (v.waits + 1));

        // Expected beat order: victim write-back, miss-block fetch, then the chained block.
        if (v.dirty) begin
            for (int i = 0; i < 4; i++) begin
                ea[ne] = v.vaddr + 32'(4 * i); ed[ne] = v.vw0 + 32'(i); ewe[ne] = 1'b1; ne++;
            end
        end
        blk = {v.addr[31:4], 4'h0};
        for (int i = 0; i < 4; i++) begin
            ea[ne] = blk + 32'(4 * i); ed[ne] = 32'd0; ewe[ne] = 1'b0; ne++;
        end
        if (v.chain_addr != 32'd0) begin
            blk = {v.chain_addr[31:4], 4'h0};
            for (int i = 0; i < 4; i++) begin
                ea[ne] = blk + 32'(4 * i); ed[ne] = 32'd0; ewe[ne] = 1'b0; ne++;
            end
        end
        for (int i = 0; i < v.exp_beats && i < nbeats && i < 16; i++) begin
            chk(vi, $sformatf("beat%0d_addr", i), la[i], ea[i]);
            chk(vi, $sformatf("beat%0d_we", i), {31'd0, lwe[i]}, {31'd0, ewe[i]});
            if (ewe[i]) chk(vi, $sformatf("beat%0d_wdata", i), ld[i], ed[i]);
        end
        if (v.exp_upd > 0 && upd_cnt > 0) begin
            last_seed = (v.chain_addr != 32'd0) ? v.seed2 : v.seed;
            for (int i = 0; i < 4; i++) begin
                chk(vi, $sformatf("fill_w%0d", i), cap[i], last_seed + 32'(i));
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 32'd0;
        cache_hit = 1'b0; cache_miss = 1'b0; victim_dirty = 1'b0; victim_addr = 32'd0;
        victim_w0 = 32'd0; victim_w1 = 32'd0; victim_w2 = 32'd0; victim_w3 = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;

        //           rd    wr    addr           hit   miss  dirty vaddr          vw0           w  seed          rst chain          seed2         st upd beats
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0124, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h0000_00A0, -1, 32'h0,         32'h0,         7, 1, 4};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_03A8, 1'b0, 1'b1, 1'b1, 32'h0000_0340, 32'h0000_0011, 0, 32'h0000_00B0, -1, 32'h0,         32'h0,        11, 1, 8};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0204, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        3, 32'h0000_00C0, -1, 32'h0,         32'h0,        19, 1, 4};
        vecs[3]  = '{1'b1, 1'b0, 32'h0001_0004, 1'b0, 1'b1, 1'b1, 32'h0000_0340, 32'h0000_0011, 0, 32'h0000_00A0, -1, 32'h0,         32'h0,         0, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0124, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h0000_00A0, -1, 32'h0,         32'h0,         0, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0124, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h0000_00A0, -1, 32'h0,         32'h0,         0, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0FF0, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0021, 1, 32'h0000_00D0, -1, 32'h0,         32'h0,        19, 1, 8};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_FFFC, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h0000_00E0, -1, 32'h0,         32'h0,         7, 1, 4};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0124, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h0000_00A0,  3, 32'h0,         32'h0,         4, 0, 2};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_02C0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h0000_00F0, -1, 32'h0,         32'h0,         7, 1, 4};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0124, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h0000_00A0, -1, 32'h0000_0460, 32'h0000_0050, 14, 2, 8};

        // Reset state with reset still applied.
        repeat (2) @(negedge CLK);
        #1;
        chk(-1, "reset_stall", {31'd0, stall}, 32'd0);
        chk(-1, "reset_update", {31'd0, update}, 32'd0);
        chk(-1, "reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk(-1, "reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk(-1, "reset_mem_addr", mem_addr, 32'd0);
        chk(-1, "reset_mem_wdata", mem_wdata, 32'd0);
        chk(-1, "reset_fill_w0", fill_w0, 32'd0);
        chk(-1, "reset_fill_w3", fill_w3, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // After the final sequence fill_w holds the last installed block through idle.
        repeat (3) @(negedge CLK);
        #1;
        chk(-1, "idle_hold_fill_w0", fill_w0, 32'h0000_0050);
        chk(-1, "idle_hold_fill_w3", fill_w3, 32'h0000_0053);
        chk(-1, "idle_update", {31'd0, update}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
